// File: rtl/rv_pkg.sv
// Shared constants for the ready/valid FIFO slice.
//   RV_DATA_WIDTH_DEFAULT : default word width (matches the downstream transfer stage data_in)
//   RV_DEPTH_DEFAULT      : default number of FIFO entries
//   rv_ptr_width()        : pointer width for a given depth (index bits plus one wrap bit)
package rv_pkg;

  localparam int unsigned RV_DATA_WIDTH_DEFAULT = 64;
  localparam int unsigned RV_DEPTH_DEFAULT      = 4;

  // Index bits plus one wrap bit so full and empty are distinguishable.
  function automatic int unsigned rv_ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rv_fifo_mem.sv
// Storage array for rv_fifo: DEPTH x DATA_WIDTH registers, no reset.
// Ports:
//   clk   - write clock
//   we    - write enable, samples wdata into entry waddr on the rising edge
//   waddr - write index
//   wdata - write word
//   raddr - read index
//   rdata - combinational read of entry raddr
module rv_fifo_mem
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH      = RV_DEPTH_DEFAULT,
  parameter int unsigned DATA_WIDTH = RV_DATA_WIDTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]      rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are never reset; the FIFO pointers make stale entries unobservable.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rv_fifo.sv
// Ready/valid first-word-fall-through FIFO.
// Optional feature: define RV_FIFO_LEVEL_EN to add the occupancy port 'level'.
// Ports:
//   clk       - single clock, rising edge
//   reset     - asynchronous, active-high; clears both pointers
//   in_valid  - producer presents in_data
//   in_ready  - FIFO not full (depends on registered pointers only)
//   in_data   - producer word
//   out_valid - FIFO not empty
//   out_ready - consumer accepts the head word
//   out_data  - head word, zero while empty
//   level     - occupancy 0..DEPTH (RV_FIFO_LEVEL_EN only)
module rv_fifo
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH      = RV_DEPTH_DEFAULT,
  parameter int unsigned DATA_WIDTH = RV_DATA_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data
`ifdef RV_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]  level
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = rv_ptr_width(DEPTH);

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Flags: equal pointers mean empty; same index with different wrap bit means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign in_ready  = !full;
  assign out_valid = !empty;

  assign push = in_valid && !full;
  assign pop  = out_ready && !empty;

  // Pointer update; the index wraps modulo DEPTH and the extra bit toggles on wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  rv_fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (push && !reset),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (mem_rdata)
  );

  // Mask the head entry while empty so stale storage never leaks out.
  assign out_data = empty ? '0 : mem_rdata;

`ifdef RV_FIFO_LEVEL_EN
  // Pointer difference is the occupancy; the wrap bit makes DEPTH representable.
  assign level = wr_ptr - rd_ptr;
`endif

endmodule

// File: tb/tb_rv_fifo.sv
// Self-checking bench for rv_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_rv_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    level;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] popped[$];

  rv_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef RV_FIFO_LEVEL_EN
    ,
    .level     (level)
`endif
  );

`ifndef RV_FIFO_LEVEL_EN
  assign level = '0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Compare all outputs against the model's view of the queue.
  task automatic check_model(input string tag);
    int n;
    n = model_q.size();
    check({tag, ".out_valid"}, DW'(out_valid), DW'(n != 0));
    check({tag, ".in_ready"},  DW'(in_ready),  DW'(n < DEPTH));
    check({tag, ".out_data"},  out_data,       (n != 0) ? model_q[0] : '0);
`ifdef RV_FIFO_LEVEL_EN
    check({tag, ".level"},     DW'(level),     DW'(n));
`endif
  endtask

  task automatic check_level(input string tag, input int unsigned exp);
`ifdef RV_FIFO_LEVEL_EN
    check(tag, DW'(level), DW'(exp));
`else
    if (tag.len() == 0 && exp == 0) $display("unused");
`endif
  endtask

  // One clock cycle: drive at negedge, check before the rising edge, update the model.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy, input string tag);
    logic do_push;
    logic do_pop;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    check_model(tag);
    do_push = iv && (model_q.size() < DEPTH);
    do_pop  = ordy && (model_q.size() != 0);
    @(posedge clk);
    if (do_pop) popped.push_back(model_q.pop_front());
    if (do_push) model_q.push_back(d);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2;
    check("rst.out_valid", DW'(out_valid), '0);
    check("rst.in_ready",  DW'(in_ready),  DW'(1));
    check("rst.out_data",  out_data,       '0);
    check_level("rst.level", 0);
    @(negedge clk);
    reset = 1'b0;

    // Single push into empty FIFO: visible exactly one cycle later.
    step(1'b1, DW'(64'hA1), 1'b0, "a1_push");
    check("a1.out_valid", DW'(out_valid), DW'(1));
    check("a1.out_data",  out_data,       DW'(64'hA1));
    check("a1.in_ready",  DW'(in_ready),  DW'(1));
    step(1'b0, '0, 1'b1, "a1_pop");
    check("a1.drained", DW'(out_valid), '0);

    // Fill to full, overflow attempt, then drain in order.
    for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b0, "fill");
    check("full.in_ready", DW'(in_ready), '0);
    check_level("full.level", 4);
    step(1'b1, DW'(5), 1'b0, "overflow");
    for (int i = 1; i <= 4; i++) begin
      check("drain.data", out_data, DW'(i));
      step(1'b0, '0, 1'b1, "drain");
    end
    check("drain.out_valid", DW'(out_valid), '0);
    check("drain.out_data",  out_data,       '0);

    // Full FIFO with pop and in_valid together: no push, in_ready rises next cycle.
    for (int i = 0; i < 4; i++) step(1'b1, DW'(8'h20 + i), 1'b0, "fill2");
    step(1'b1, DW'(64'h77), 1'b1, "full_pop");
    check("fullpop.in_ready", DW'(in_ready), DW'(1));
    check("fullpop.head",     out_data,      DW'(8'h21));
    check_level("fullpop.level", 3);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, "drain2");
    check("drain2.out_valid", DW'(out_valid), '0);

    // Two entries, then push+pop every cycle across pointer wrap.
    step(1'b1, DW'(8'h0E), 1'b0, "pre0");
    step(1'b1, DW'(8'h0F), 1'b0, "pre1");
    popped.delete();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, DW'(8'h10 + i), 1'b1, "stream");
      check_level("stream.level", 2);
    end
    for (int i = 0; i < 10; i++) check("stream.order", popped[i], DW'(8'h0E + i));
    step(1'b0, '0, 1'b1, "drain3");
    step(1'b0, '0, 1'b1, "drain3");

    // Asynchronous reset mid-stream with three entries.
    for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h30 + i), 1'b0, "pre_rst");
    in_valid  = 1'b1;
    in_data   = DW'(64'hBAD);
    out_ready = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    check("arst.out_valid", DW'(out_valid), '0);
    check("arst.out_data",  out_data,       '0);
    check("arst.in_ready",  DW'(in_ready),  DW'(1));
    check_level("arst.level", 0);
    @(posedge clk);
    @(negedge clk);
    model_q.delete();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("arst.discard", DW'(out_valid), '0);

    // out_ready while empty: nothing moves; next push behaves normally.
    step(1'b0, '0, 1'b1, "empty_pop");
    step(1'b0, '0, 1'b1, "empty_pop");
    check("emptypop.out_valid", DW'(out_valid), '0);
    check_level("emptypop.level", 0);
    step(1'b1, DW'(64'h36), 1'b0, "after_empty");
    check("afterempty.data", out_data, DW'(64'h36));
    step(1'b0, '0, 1'b1, "drain4");

    // Randomized traffic against the queue model, with stall checks on the head.
    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] held;
      logic          stalled;
      held    = out_data;
      stalled = out_valid;
      step(1'($urandom_range(0, 99) < 60), {$urandom, $urandom}, 1'($urandom_range(0, 99) < 45), "rand");
      if (stalled && popped.size() == 0) check("rand.stable", out_data, held);
      popped.delete();
    end
    check_model("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv_fifo.md
RV_FIFO -- requirements
Module: rv_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of 64-bit entries; power of two, minimum 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, word width; matches the downstream transfer stage's data_in.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  producer presents a word.
REQ-006 SHALL have port in_ready  output  1  FIFO can accept a word this cycle.
REQ-007 SHALL have port in_data  input  DATA_WIDTH  producer word.
REQ-008 SHALL have port out_valid  output  1  head word available; drives the downstream valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the head word.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  head word; drives the downstream data_in.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  occupancy; present only under RV_FIFO_LEVEL_EN.

Function
REQ-012 SHALL accept (push) on a rising edge when in_valid && in_ready; SHALL pop when out_valid && out_ready.
REQ-013 SHALL drive in_ready = !full, registered-state-only; no combinational path from out_ready to in_ready.
REQ-014 SHALL drive out_valid = !empty; out_data = entry at read pointer, first-word-fall-through; out_data = 0 while empty.
REQ-015 SHALL give push-to-out_valid latency of exactly 1 cycle into an empty FIFO; no same-cycle bypass.
REQ-016 SHALL keep read/write pointers of $clog2(DEPTH)+1 bits; empty = pointers equal; full = index bits equal, MSB differs.
REQ-017 SHALL wrap pointer index modulo DEPTH; MSB toggles on wrap.
REQ-018 SHALL, on simultaneous push and pop while neither full nor empty, advance both pointers; occupancy unchanged.
REQ-019 SHALL, when full, ignore in_valid (in_ready=0); a pop in that cycle makes in_ready=1 on the next cycle only.
REQ-020 SHALL, when empty, ignore out_ready; no pointer movement, no underflow.
REQ-021 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-022 SHALL preserve strict FIFO order; no word dropped or duplicated.

Reset
REQ-023 SHALL, on reset assertion at any time, including mid-transfer, clear both pointers asynchronously: out_valid=0, in_ready=1, out_data=0, level=0.
REQ-024 SHALL NOT reset storage entries; contents become unobservable via empty state.
REQ-025 SHALL discard any handshake coinciding with reset.

Configuration
REQ-026 SHALL, with RV_FIFO_LEVEL_EN defined, add port level = write_ptr - read_ptr (0..DEPTH), updated with the pointers.
REQ-027 SHALL, without RV_FIFO_LEVEL_EN, omit the level port and all logic beyond pointers; behaviour otherwise identical.

Structure
REQ-028 SHALL place DATA_WIDTH default (64) and default DEPTH constant in shared package rv_pkg.
REQ-029 SHALL implement storage as sub-module rv_fifo_mem: DEPTH x DATA_WIDTH register array, one synchronous write port, one combinational read port, no reset.
REQ-030 SHALL keep pointer, flag and level logic in rv_fifo.

Verification
REQ-031 SHALL cover reset, then push 0xA1 with out_ready=0 -> out_valid=1 next cycle, out_data=0xA1, in_ready=1.
REQ-032 SHALL cover 4 pushes 0x1..0x4 with out_ready=0 -> in_ready=0 after 4th; 5th word 0x5 not stored; pops return 0x1,0x2,0x3,0x4 then out_valid=0.
REQ-033 SHALL cover full FIFO with simultaneous pop and in_valid -> no push that cycle; in_ready=1 next cycle; level 4->3 (macro on).
REQ-034 SHALL cover 2 entries, then push and pop every cycle for 10 cycles (values 0x10..0x19) -> level stays 2; output order 0x10.. preserved across pointer wrap.
REQ-035 SHALL cover reset asserted mid-stream with 3 entries -> out_valid=0, out_data=0, in_ready=1, level=0 immediately, before the next clock edge.
REQ-036 SHALL cover out_ready pulsed while empty -> no state change; level=0; first push afterwards appears normally.
